// File: rtl/nmos_sipo_rx_if.sv
// rtl/nmos_sipo_rx_if.sv - phase-enable, serial-in and parallel-out bundle for nmos_sipo_rx
interface nmos_sipo_rx_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             C1;
  logic             C2;
  logic             D;
  logic             SH;
  logic             LD;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;
  logic [WIDTH-1:0] SQ;
  logic [CW-1:0]    CNT;
  logic             RDY;
  logic             OVF;
  logic             ERR;

  modport master (
    output C1, C2, D, SH, LD,
    input  Q, Q_n, SQ, CNT, RDY, OVF, ERR
  );

  modport slave (
    input  C1, C2, D, SH, LD,
    output Q, Q_n, SQ, CNT, RDY, OVF, ERR
  );
endinterface

// File: rtl/nmos_sipo_rx.sv
// rtl/nmos_sipo_rx.sv - two-phase serial-in parallel-out receive register
module nmos_sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          main_clk,
  input  logic          rst,
  nmos_sipo_rx_if.slave rx
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shift_word;
  logic [CW-1:0]    cnt;
  logic             pend;
  logic             ovf;
  logic             err;

  // Shift always feeds from the committed slave stage, so repeated PHI2
  // shifts without a PHI1 commit overwrite rather than accumulate.
  always_comb begin
    shift_word = '0;
    if (MSB_FIRST) shift_word = {s1[WIDTH-2:0], rx.D};
    else           shift_word = {rx.D, s1[WIDTH-1:1]};
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      q    <= '0;
      cnt  <= '0;
      pend <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (rx.LD) begin
        q   <= s1;
        ovf <= 1'b0;
        cnt <= '0;
      end
      if (rx.C1 && rx.C2) begin
        err <= 1'b1;
      end else if (rx.C2) begin
        if (rx.SH) begin
          s2   <= shift_word;
          pend <= 1'b1;
        end
      end else if (rx.C1) begin
        s1 <= s2;
        if (pend) begin
          pend <= 1'b0;
          // A load on the commit edge restarts the count with this bit.
          if (rx.LD)            cnt <= CW'(1);
          else if (cnt == FULL) ovf <= 1'b1;
          else                  cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign rx.Q   = q;
  assign rx.Q_n = ~q;
  assign rx.SQ  = s1;
  assign rx.CNT = cnt;
  assign rx.RDY = (cnt == FULL);
  assign rx.OVF = ovf;
  assign rx.ERR = err;
endmodule

// File: tb/tb_nmos_sipo_rx.sv
// tb/tb_nmos_sipo_rx.sv - directed bench for nmos_sipo_rx, MSB-first and LSB-first instances
module tb_nmos_sipo_rx;
  logic main_clk;
  logic rst;
  int   checks;
  int   errors;

  nmos_sipo_rx_if #(.WIDTH(8)) m_if ();
  nmos_sipo_rx_if #(.WIDTH(8)) l_if ();

  assign l_if.C1 = m_if.C1;
  assign l_if.C2 = m_if.C2;
  assign l_if.D  = m_if.D;
  assign l_if.SH = m_if.SH;
  assign l_if.LD = m_if.LD;

  nmos_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .main_clk (main_clk),
    .rst      (rst),
    .rx       (m_if.slave)
  );

  nmos_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .main_clk (main_clk),
    .rst      (rst),
    .rx       (l_if.slave)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c1, input logic c2, input logic sh, input logic d, input logic ld);
    m_if.C1 = c1;
    m_if.C2 = c2;
    m_if.SH = sh;
    m_if.D  = d;
    m_if.LD = ld;
    @(posedge main_clk);
    #1;
    m_if.C1 = 1'b0;
    m_if.C2 = 1'b0;
    m_if.SH = 1'b0;
    m_if.D  = 1'b0;
    m_if.LD = 1'b0;
  endtask

  task automatic bit_in(input logic d);
    cyc(1'b0, 1'b1, 1'b1, d, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bits_in(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(word[i]);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    m_if.C1 = 1'b0;
    m_if.C2 = 1'b0;
    m_if.SH = 1'b0;
    m_if.D  = 1'b0;
    m_if.LD = 1'b0;
    #12;
    chk("rst_q",   32'(m_if.Q),   32'h00);
    chk("rst_qn",  32'(m_if.Q_n), 32'hFF);
    chk("rst_sq",  32'(m_if.SQ),  32'h00);
    chk("rst_cnt", 32'(m_if.CNT), 32'd0);
    chk("rst_rdy", 32'(m_if.RDY), 32'd0);
    chk("rst_ovf", 32'(m_if.OVF), 32'd0);
    chk("rst_err", 32'(m_if.ERR), 32'd0);
    rst = 1'b0;

    // word 1,0,1,0,0,1,0,1 on both bit orders
    bits_in(32'b1010010, 7);
    chk("w_rdy7", 32'(m_if.RDY), 32'd0);
    chk("w_cnt7", 32'(m_if.CNT), 32'd7);
    bit_in(1'b1);
    chk("w_rdy",    32'(m_if.RDY), 32'd1);
    chk("w_sq",     32'(m_if.SQ),  32'hA5);
    chk("w_sq_lsb", 32'(l_if.SQ),  32'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w_q",     32'(m_if.Q),   32'hA5);
    chk("w_qn",    32'(m_if.Q_n), 32'h5A);
    chk("w_cnt0",  32'(m_if.CNT), 32'd0);
    chk("w_rdy0",  32'(m_if.RDY), 32'd0);

    // 1,1,0,0,0,0,0,0: MSB-first gives C0, LSB-first gives 03
    bits_in(32'b11000000, 8);
    chk("l_sq_lsb", 32'(l_if.SQ), 32'h03);
    chk("l_sq_msb", 32'(m_if.SQ), 32'hC0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // overflow: nine bits, oldest one drops out
    bits_in(32'b101001011, 9);
    chk("o_sq",  32'(m_if.SQ),  32'h4B);
    chk("o_cnt", 32'(m_if.CNT), 32'd8);
    chk("o_ovf", 32'(m_if.OVF), 32'd1);
    chk("o_rdy", 32'(m_if.RDY), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("o_q",    32'(m_if.Q),   32'h4B);
    chk("o_ovf0", 32'(m_if.OVF), 32'd0);
    chk("o_cnt0", 32'(m_if.CNT), 32'd0);

    // partial word from a clean slave stage
    do_reset();
    bits_in(32'b110, 3);
    chk("p_cnt3", 32'(m_if.CNT), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p_q",    32'(m_if.Q),   32'h06);
    chk("p_cnt0", 32'(m_if.CNT), 32'd0);
    chk("p_rdy",  32'(m_if.RDY), 32'd0);

    // two PHI2 shifts before one commit: only the last D survives
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("d_sq",  32'(m_if.SQ),  32'h0C);
    chk("d_cnt", 32'(m_if.CNT), 32'd1);

    // load on the same edge as a pending commit
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s_q",   32'(m_if.Q),   32'h0C);
    chk("s_cnt", 32'(m_if.CNT), 32'd1);
    chk("s_sq",  32'(m_if.SQ),  32'h19);

    // phase overlap with SQ=3C
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bits_in(32'b00111100, 8);
    chk("e_sq0", 32'(m_if.SQ), 32'h3C);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("e_err", 32'(m_if.ERR), 32'd1);
    chk("e_sq",  32'(m_if.SQ),  32'h3C);
    chk("e_cnt", 32'(m_if.CNT), 32'd8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("e_pend_cnt", 32'(m_if.CNT), 32'd8);
    chk("e_pend_ovf", 32'(m_if.OVF), 32'd0);
    chk("e_pend_sq",  32'(m_if.SQ),  32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("e_sticky", 32'(m_if.ERR), 32'd1);

    // asynchronous reset between edges, mid-word
    bits_in(32'b11111, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("a_q",   32'(m_if.Q),   32'h00);
    chk("a_qn",  32'(m_if.Q_n), 32'hFF);
    chk("a_sq",  32'(m_if.SQ),  32'h00);
    chk("a_cnt", 32'(m_if.CNT), 32'd0);
    chk("a_err", 32'(m_if.ERR), 32'd0);
    #1;
    rst = 1'b0;
    bit_in(1'b1);
    chk("a_cnt1", 32'(m_if.CNT), 32'd1);
    bits_in(32'b1111111, 7);
    chk("a_sq_ff", 32'(m_if.SQ),  32'hFF);
    chk("a_cnt8",  32'(m_if.CNT), 32'd8);
    chk("a_rdy",   32'(m_if.RDY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
